// File: rtl/pe_mac_seq_if.sv
// Operand-in / result-out handshake bundle for the pe_mac_seq dot-product engine.
// master = feeder/collector side, slave = the MAC engine.
interface pe_mac_seq_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*A_W-1:0]   a_vec;
    logic [LANES*B_W-1:0]   b_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic                   out_bit;
    logic                   out_sat;

    modport master (
        output in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_data, out_bit, out_sat
    );

    modport slave (
        input  in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_data, out_bit, out_sat
    );
endinterface

// File: rtl/pe_mac_seq.sv
// Multi-lane saturating MAC: accumulates cfg_len beats of LANES unsigned*signed products,
// then presents a thresholded / ReLU'd result on a held valid/ready output.
module pe_mac_seq #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_bit_sel,
    input  logic             cfg_relu_en,
    input  logic [ACC_W-1:0] cfg_thresh,
    pe_mac_seq_if.slave      bus,
    output logic             busy
);
    localparam int PW = A_W + B_W;
    localparam int SW = PW + $clog2(LANES);
    localparam int EW = ((ACC_W > SW) ? ACC_W : SW) + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  r_state, w_state_next;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt, r_len;
    logic                    r_sat, r_bit_sel, r_relu_en;
    logic [ACC_W-1:0]        r_thresh;
    logic                    r_out_valid, r_out_bit, r_out_sat;
    logic [ACC_W-1:0]        r_out_data;

    logic signed [PW-1:0]    w_prod [LANES];
    logic signed [SW-1:0]    w_psum [LANES+1];
    logic signed [SW-1:0]    w_beat;
    logic signed [ACC_W-1:0] w_base, w_acc_sat;
    logic signed [EW-1:0]    w_total;
    logic                    w_hi, w_lo, w_first, w_last, w_in_ready, w_accept;
    logic [CNT_W-1:0]        w_len, w_cnt_inc;
    logic [ACC_W-1:0]        w_thresh, w_val, w_data;
    logic                    w_bit_sel, w_relu_en, w_sat_any, w_bit;

    assign w_psum[0] = '0;
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_prod[gi] = PW'($signed({1'b0, bus.a_vec[gi*A_W +: A_W]}))
                              * PW'($signed(bus.b_vec[gi*B_W +: B_W]));
            assign w_psum[gi+1] = w_psum[gi] + SW'(w_prod[gi]);
        end
    endgenerate
    assign w_beat = w_psum[LANES];

    // First beat starts from zero and uses the live config; later beats use latched values.
    assign w_first   = (r_state == IDLE);
    assign w_base    = w_first ? '0 : r_acc;
    assign w_total   = EW'(w_base) + EW'(w_beat);
    assign w_hi      = (w_total > EW'(ACC_MAX));
    assign w_lo      = (w_total < EW'(ACC_MIN));
    assign w_acc_sat = w_hi ? ACC_MAX : (w_lo ? ACC_MIN : w_total[ACC_W-1:0]);

    assign w_len     = w_first ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : r_len;
    assign w_thresh  = w_first ? cfg_thresh  : r_thresh;
    assign w_bit_sel = w_first ? cfg_bit_sel : r_bit_sel;
    assign w_relu_en = w_first ? cfg_relu_en : r_relu_en;
    assign w_sat_any = (w_first ? 1'b0 : r_sat) | w_hi | w_lo;
    assign w_cnt_inc = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == w_len);

    // Threshold uses the pre-ReLU value.
    assign w_bit  = ($signed(w_acc_sat) >= $signed(w_thresh));
    assign w_val  = (w_relu_en && w_acc_sat[ACC_W-1]) ? '0 : w_acc_sat;
    assign w_data = w_bit_sel ? {{(ACC_W-1){1'b0}}, w_bit} : w_val;

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE, ACCUM: w_in_ready = !clr;
            HOLD:        w_in_ready = 1'b0;
            default:     w_in_ready = 1'b0;
        endcase
        w_accept = w_in_ready && bus.in_valid;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = w_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (w_accept && w_last) w_state_next = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (clr) w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_sat       <= 1'b0;
            r_bit_sel   <= 1'b0;
            r_relu_en   <= 1'b0;
            r_thresh    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_bit   <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_bit   <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc <= w_acc_sat;
                r_cnt <= w_cnt_inc;
                r_sat <= w_sat_any;
                if (w_first) begin
                    r_len     <= w_len;
                    r_thresh  <= cfg_thresh;
                    r_bit_sel <= cfg_bit_sel;
                    r_relu_en <= cfg_relu_en;
                end
                if (w_last) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_data;
                    r_out_bit   <= w_bit;
                    r_out_sat   <= w_sat_any;
                end
            end
            if (r_state == HOLD && bus.out_ready) r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_sat   = r_out_sat;
    assign busy          = (r_state != IDLE);
endmodule

// File: doc/pe_mac_seq.md
Name: pe_mac_seq

Overview:
Parametrised successor to the single-lane PE MAC core. Each accepted beat multiplies LANES unsigned A operands by LANES signed B operands and sums the products into one accumulator. After a programmable number of beats, the block post-processes the dot product: saturation, threshold decision bit, and optional ReLU. It returns the result over a valid/ready output register with backpressure. It sits between the operand feeder and the layer output collector.

Parameters:
A_W, 8, width of each unsigned A operand
B_W, 8, width of each signed B operand
LANES, 4, parallel multiplier lanes per beat
ACC_W, 24, signed accumulator and result width
CNT_W, 8, width of the beat-count config

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
clr  input  1  synchronous abort; returns to IDLE and discards partial sum and pending output
cfg_len  input  CNT_W  beats per dot product; 0 is treated as 1; sampled on first beat
cfg_bit_sel  input  1  1: out_data carries the decision bit zero-extended; sampled on first beat
cfg_relu_en  input  1  1: apply ReLU to out_data; sampled on first beat
cfg_thresh  input  ACC_W  signed decision threshold; sampled on first beat
in_valid  input  1  operand beat valid
in_ready  output  1  beat accepted when in_valid&&in_ready
a_vec  input  LANES*A_W  lane i at [i*A_W +: A_W], unsigned
b_vec  input  LANES*B_W  lane i at [i*B_W +: B_W], signed
out_valid  output  1  result held valid until accepted
out_ready  input  1  downstream accept
out_data  output  ACC_W  post-processed result (signed)
out_bit  output  1  decision: final_acc >= cfg_thresh (signed compare)
out_sat  output  1  accumulator saturated at least once during this dot product
busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge) overrides everything, including clr. Every register clears: state=IDLE; out_valid, out_data, out_bit, out_sat, busy=0; beat counter and accumulator=0.
- Products:
  - lane product = {1'b0,a} * signed b, width A_W+B_W, signed.
  - Beat sum width A_W+B_W+clog2(LANES), signed, exact (no overflow possible).
- Accumulator is ACC_W signed with saturating add:
  - Clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Any clamp sets a sticky sat flag for the current dot product.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. An accepted beat latches cfg_*, loads acc = sat(beat sum), counter=1.
    - If the effective length is 1, go to HOLD.
    - Otherwise go to ACCUM.
  - ACCUM: in_ready=1. An accepted beat does acc = sat(acc + beat sum) and increments the counter.
    - When the counter reaches the effective length, go to HOLD.
    - Cycles with no accepted beat hold all state.
  - HOLD: in_ready=0; out_valid=1.
    - out_data, out_bit and out_sat are registered on the transition into HOLD and stay stable until the handshake.
    - out_valid&&out_ready moves to IDLE and drops out_valid on the next edge.
- Latency: out_valid rises the cycle after the final beat is accepted. Minimum period per dot product is len+1 cycles when out_ready=1.
- Post-processing, computed on final_acc (saturated, including the last beat):
  - out_bit = (final_acc >= cfg_thresh).
  - val = (cfg_relu_en && final_acc<0) ? 0 : final_acc.
  - out_data = cfg_bit_sel ? {(ACC_W-1)'b0, out_bit} : val.
  - The threshold compare always uses the pre-ReLU value.
- clr=1: in_ready is forced 0 that cycle, so a beat presented with clr is not accepted. Next state is IDLE; accumulator, counter and sat flag clear; out_valid=0. This applies in all states, including HOLD.
- cfg_* changes after the first beat have no effect until the next dot product.
- The counter never wraps: cfg_len=2^CNT_W-1 is the maximum.

Test Plan:
- LANES=4, cfg_len=1, a=[1,2,3,4], b=[1,1,1,1], out_ready=1 -> out_valid one cycle after the beat, out_data=10, out_sat=0, back in IDLE the following cycle.
- cfg_len=3, the same beat three times with idle gaps between beats -> out_data=30; no out_valid before the third beat.
- cfg_len=1, all a=255, all b=-128, cfg_thresh=0 -> relu_en=0: out_data=-130560, out_bit=0; relu_en=1: out_data=0, out_bit=0; bit_sel=1: out_data=0.
- All a=255, all b=127 (beat sum 129540), cfg_len=65 -> out_data=8388607, out_sat=1; a following len=1 dot product shows out_sat=0.
- Result pending with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; the handshake on cycle 6 returns to IDLE.
- reset_n=0 mid-ACCUM, and clr=1 in HOLD -> outputs 0 next edge; a fresh len=1 beat then yields the correct result with no residue.
